// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter and the RAM wrapper beside it.
// Owner codes tag which port issued the read that is in flight.
package dmem_pkg;

  localparam int DEF_AWIDTH = 8;
  localparam int DEF_DWIDTH = 16;

  typedef logic [1:0] owner_t;

  localparam owner_t OWN_NONE = 2'd0;
  localparam owner_t OWN_A    = 2'd1;
  localparam owner_t OWN_B    = 2'd2;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported RAM: A has default priority,
// B wins after MAX_WAIT consecutive denied cycles; read data is steered back by owner.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AWIDTH   = DEF_AWIDTH,
  parameter int DWIDTH   = DEF_DWIDTH,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [AWIDTH-1:0] a_addr,
  input  logic [DWIDTH-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DWIDTH-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [AWIDTH-1:0] b_addr,
  input  logic [DWIDTH-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DWIDTH-1:0] b_rdata,
  output logic              m_rd,
  output logic              m_wr,
  output logic [AWIDTH-1:0] m_raddr,
  output logic [AWIDTH-1:0] m_waddr,
  output logic [DWIDTH-1:0] m_wdata,
  input  logic [DWIDTH-1:0] m_rdata
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic [3:0]        wait_cnt;
  owner_t            rd_owner;
  logic              b_force;
  logic              win;
  logic              win_we;
  logic [AWIDTH-1:0] win_addr;
  logic [DWIDTH-1:0] win_wdata;

  assign b_force = (wait_cnt == WAIT_MAX);

  // Grants are masked during reset so the RAM sees no strobes.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!rst) begin
      b_gnt = b_req && (!a_req || b_force);
      a_gnt = a_req && !b_gnt;
    end
  end

  assign win       = a_gnt | b_gnt;
  assign win_we    = b_gnt ? b_we    : a_we;
  assign win_addr  = b_gnt ? b_addr  : a_addr;
  assign win_wdata = b_gnt ? b_wdata : a_wdata;

  assign m_wr    = win &  win_we;
  assign m_rd    = win & ~win_we;
  assign m_waddr = m_wr ? win_addr  : '0;
  assign m_wdata = m_wr ? win_wdata : '0;
  assign m_raddr = m_rd ? win_addr  : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      rd_owner <= OWN_NONE;
    end else begin
      if (b_req && !b_gnt)
        wait_cnt <= b_force ? WAIT_MAX : wait_cnt + 4'd1;
      else
        wait_cnt <= '0;
      if (m_rd)
        rd_owner <= b_gnt ? OWN_B : OWN_A;
      else
        rd_owner <= OWN_NONE;
    end
  end

  // A read issued just before reset must not surface while reset is held.
  assign a_rvalid = !rst && (rd_owner == OWN_A);
  assign b_rvalid = !rst && (rd_owner == OWN_B);
  assign a_rdata  = m_rdata;
  assign b_rdata  = m_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a behavioural RAM beside it.
module tb_dmem_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          m_rd, m_wr;
  logic [AW-1:0] m_raddr, m_waddr;
  logic [DW-1:0] m_wdata, m_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  dmem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .m_rd(m_rd), .m_wr(m_wr), .m_raddr(m_raddr), .m_waddr(m_waddr),
    .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM: one op per clock, registered read, read wins if both strobes high.
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (m_rd) m_rdata <= ram[m_raddr];
    else if (m_wr) ram[m_waddr] <= m_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Reference model: memory image, B's denied-cycle count, expected returns.
  typedef struct { int cyc; bit port; logic [DW-1:0] data; } rsp_t;
  rsp_t          q[$];
  logic [DW-1:0] ref_mem [256];
  int            denied = 0;

  always @(negedge clk) begin
    bit            eb, ea, we;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    rsp_t          r;
    if (rst) begin
      chk("rst_a_gnt", 32'(a_gnt), 0);
      chk("rst_b_gnt", 32'(b_gnt), 0);
      chk("rst_m_rd", 32'(m_rd), 0);
      chk("rst_m_wr", 32'(m_wr), 0);
      denied = 0;
    end else begin
      eb = b_req && (!a_req || denied == MW);
      ea = a_req && !eb;
      we = eb ? b_we : a_we;
      ad = eb ? b_addr : a_addr;
      wd = eb ? b_wdata : a_wdata;
      chk("a_gnt", 32'(a_gnt), 32'(ea));
      chk("b_gnt", 32'(b_gnt), 32'(eb));
      chk("m_rd", 32'(m_rd), 32'((ea || eb) && !we));
      chk("m_wr", 32'(m_wr), 32'((ea || eb) && we));
      chk("m_raddr", 32'(m_raddr), ((ea || eb) && !we) ? 32'(ad) : 0);
      chk("m_waddr", 32'(m_waddr), ((ea || eb) && we) ? 32'(ad) : 0);
      chk("m_wdata", 32'(m_wdata), ((ea || eb) && we) ? 32'(wd) : 0);
      if ((ea || eb) && we) ref_mem[ad] = wd;
      if ((ea || eb) && !we) begin
        r.cyc = cyc + 1; r.port = eb; r.data = ref_mem[ad];
        q.push_back(r);
      end
      if (b_req && !eb) denied = (denied < MW) ? denied + 1 : MW;
      else denied = 0;
    end
  end

  // Monitor: each cycle, the port owed a return (if any) must be the only rvalid.
  always @(negedge clk) begin
    bit            xa, xb;
    logic [DW-1:0] xd;
    rsp_t          r;
    xa = 0; xb = 0; xd = '0;
    if (q.size() > 0 && q[0].cyc <= cyc) begin
      r = q.pop_front();
      if (!rst && r.cyc == cyc) begin
        xa = !r.port; xb = r.port; xd = r.data;
      end
    end
    chk("a_rvalid", 32'(a_rvalid), 32'(xa));
    chk("b_rvalid", 32'(b_rvalid), 32'(xb));
    if (xa) chk("a_rdata", 32'(a_rdata), 32'(xd));
    if (xb) chk("b_rdata", 32'(b_rdata), 32'(xd));
  end

  task automatic issue(input bit pb, input bit we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    int n = 0;
    bit g;
    if (pb) begin b_req = 1; b_we = we; b_addr = ad; b_wdata = d; end
    else    begin a_req = 1; a_we = we; a_addr = ad; a_wdata = d; end
    do begin
      @(negedge clk);
      g = pb ? b_gnt : a_gnt;
      n++;
    end while (!g && n < 20);
    if (!g) begin
      checks++; errors++;
      $display("FAIL issue_timeout port=%0d got=no_gnt expected=gnt", pb);
    end
    @(posedge clk); #1;
    if (pb) b_req = 0; else a_req = 0;
  endtask

  task automatic cycle_drive(input int pa, input int pb, input int pw);
    bit ag, bg;
    @(negedge clk); ag = a_gnt; bg = b_gnt;
    @(posedge clk); #1;
    if (a_req && !ag) begin
      if (int'($urandom_range(99)) < pw) a_req = 0;
    end else begin
      a_req = int'($urandom_range(99)) < pa;
      a_we = 1'($urandom_range(1)); a_addr = 8'($urandom_range(15)); a_wdata = 16'($urandom);
    end
    if (b_req && !bg) begin
      if (int'($urandom_range(99)) < pw) b_req = 0;
    end else begin
      b_req = int'($urandom_range(99)) < pb;
      b_we = 1'($urandom_range(1)); b_addr = 8'($urandom_range(15)); b_wdata = 16'($urandom);
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 16'(i * 37 + 5);
      ref_mem[i] = 16'(i * 37 + 5);
    end
    ram[5] = 16'h1234; ref_mem[5] = 16'h1234;
    ram[1] = 16'h0011; ref_mem[1] = 16'h0011;
    ram[2] = 16'h0022; ref_mem[2] = 16'h0022;

    rst = 1; a_req = 1; b_req = 1; a_we = 0; b_we = 0;
    a_addr = 8'h20; b_addr = 8'h21; a_wdata = '0; b_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("first_gnt_after_reset_a", 32'(a_gnt), 1);
    @(posedge clk); #1 a_req = 0; b_req = 0;

    issue(0, 0, 8'h05, '0);
    issue(1, 1, 8'h10, 16'hBEEF);
    issue(1, 0, 8'h10, '0);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      issue(0, 0, 8'h01, '0);
      issue(1, 0, 8'h02, '0);
    end

    repeat (25) cycle_drive(100, 100, 0);
    @(posedge clk); #1 a_req = 0; b_req = 0;

    // Withdrawal must reset B's wait: full MAX_WAIT denials needed again.
    a_req = 1; a_we = 0; a_addr = 8'h03; b_req = 1; b_we = 0; b_addr = 8'h04;
    repeat (2) @(posedge clk);
    #1 b_req = 0;
    @(posedge clk);
    #1 b_req = 1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (b_gnt) break;
      n++;
    end
    chk("withdraw_rewait", 32'(n), MW);
    @(posedge clk); #1 a_req = 0; b_req = 0;

    issue(0, 0, 8'h07, '0);
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    repeat (1500) cycle_drive(60, 60, 10);
    @(posedge clk); #1 a_req = 0; b_req = 0;
    repeat (4) @(posedge clk);
    #1 chk("scoreboard_drained", 32'(q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
